// File: rtl/uart_tx_fifo_pkg.sv
// Purpose: shared defaults for the UART transmit buffer, used by the peripheral top for overrides.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_tx_fifo_pkg;

    // Byte width presented to the transmitter.
    localparam int UART_TX_FIFO_DATA_W = 8;
    // Number of queued bytes; must be a power of two, >= 2.
    localparam int UART_TX_FIFO_DEPTH  = 16;
    // Low-watermark level: wm asserts while occupancy <= this value.
    localparam int UART_TX_FIFO_WM     = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: show-ahead byte FIFO feeding the UART transmitter, with level/full/empty/watermark/overflow status.
// Latency: push to tx_valid_o is 1 cycle; tx_data_o is combinational from the head entry (no read latency).
// Backpressure: wr_ready_o = !full (a write while full is dropped and sets sticky ovf_o); pops only on tx_ready_i.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   clr_i                             synchronous flush (pointers, level, overflow)
//   wr_data_i/wr_valid_i/wr_ready_o   enqueue side
//   tx_data_o/tx_valid_o/tx_ready_i   dequeue side, to the transmitter
//   level_o, empty_o, full_o, wm_o    occupancy status
//   ovf_o                             sticky write-while-full flag
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W   = UART_TX_FIFO_DATA_W,
    parameter int DEPTH    = UART_TX_FIFO_DEPTH,
    parameter int WM_LEVEL = UART_TX_FIFO_WM
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic                     tx_valid_o,
    input  logic                     tx_ready_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     wm_o,
    output logic                     ovf_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVL_W = IDX_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the indices coincide.
    logic [IDX_W:0]      wr_ptr;
    logic [IDX_W:0]      rd_ptr;
    logic [LVL_W-1:0]    level;
    logic                ovf;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];

    // Single compares of pointer flops.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);

    // When full only the pop can fire; when empty only the push can fire.
    assign push = wr_valid_i && !full;
    assign pop  = !empty && tx_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (clr_i) begin
            // Flush wins over any same-cycle push/pop.
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            if (wr_valid_i && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; only slots below the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (push && !clr_i) begin
            mem[wr_idx] <= wr_data_i;
        end
    end

    assign tx_data_o  = mem[rd_idx];
    assign tx_valid_o = !empty;
    assign wr_ready_o = !full;
    assign level_o    = level;
    assign empty_o    = empty;
    assign full_o     = full;
    assign wm_o       = (level <= LVL_W'(WM_LEVEL));
    assign ovf_o      = ovf;

endmodule
